multi_timer: RTL
================

// Module: multi_timer
// PURPOSE
//  Multi-channel programmable down-counting timer for the 8-bit CPU peripheral set.
//  - Every channel has its own reload value, one-shot/periodic mode, timeout pulse and sticky interrupt flag.
//  - All channels share one clock prescaler.
//  - Drives a single combined irq line into the CPU interrupt logic.
// PARAMETERS
//  NUM_CH      4   number of timer channels (>=1)
//  WIDTH       16  counter / reload width in bits
//  PRESC_W     8   prescaler divider width in bits
// PORTS
//  clk          in   1              clock
//  rst          in   1              reset, synchronous, active-high
//  presc_div    in   PRESC_W        tick every presc_div+1 clk cycles (0 = every cycle)
//  cfg_we       in   1              write reload/mode for channel cfg_ch
//  cfg_ch       in   max(1,$clog2(NUM_CH))  channel select for cfg_we
//  cfg_reload   in   WIDTH          reload value to store
//  cfg_periodic in   1              1 = auto-reload, 0 = one-shot
//  start        in   NUM_CH         per-channel 1-cycle start/restart pulse
//  stop         in   NUM_CH         per-channel 1-cycle stop pulse
//  irq_en       in   NUM_CH         per-channel interrupt enable
//  irq_clr      in   NUM_CH         per-channel pending-flag clear pulse
//  running      out  NUM_CH         channel is in RUN state
//  timeout      out  NUM_CH         1-cycle pulse at each expiry
//  pending      out  NUM_CH         sticky expiry flag
//  count        out  NUM_CH*WIDTH   current counts, channel i at [i*WIDTH +: WIDTH]
//  irq          out  1              |(pending & irq_en), combinational from registers
// BEHAVIOUR
//  Reset:
//  - Prescaler counter = 0.
//  - Every channel: reload = 0, periodic = 0, count = 0, state = IDLE.
//  - running, timeout and pending all 0; irq therefore 0.
//  Prescaler:
//  - Free-running counter 0..presc_div.
//  - tick = 1 in the cycle the counter equals presc_div; the counter wraps to 0 on the next edge.
//  - A change to presc_div takes effect at the next wrap.
//  - If the counter is already above a newly lowered presc_div, it counts up to its all-ones value, then wraps.
//  - The prescaler is shared, so a channel's first period after start has up to presc_div cycles of phase uncertainty.
//  Configuration:
//  - cfg_we writes the reload and periodic registers of channel cfg_ch.
//  - cfg_ch >= NUM_CH is ignored.
//  - A write never alters a live count; the new values apply at the next start or auto-reload.
//  Per-channel FSM (IDLE, RUN), priority rst > start > stop > tick:
//  - start (any state): count <= reload, state <= RUN. A start while in RUN restarts the channel.
//  - stop: state <= IDLE, count holds its value, no timeout.
//  - RUN, tick, count != 0: count <= count - 1.
//  - RUN, tick, count == 0: timeout pulse and pending set. If periodic, count <= reload and stay in RUN.
//    If one-shot, go to IDLE with count held at 0.
//  - IDLE: count holds, and ticks are ignored.
//  Timing:
//  - The period is reload+1 ticks.
//  - With presc_div = 0 and start sampled at edge N: running = 1 and count = reload from cycle N+1.
//  - timeout is high exactly one cycle, at cycle N+1+reload+1.
//  - running drops in that same cycle for a one-shot channel.
//  Pending flag:
//  - Set by expiry; cleared by irq_clr.
//  - A set and a clear in the same cycle leave it 1 (set wins).
//  - irq_en masks only irq, never pending.
//  reload = 0:
//  - Expires on every tick.
//  - In periodic mode with presc_div = 0, timeout stays high continuously.
//  Independence:
//  - Channels are fully independent.
//  - Simultaneous events on different channels are all honoured in the same cycle.
//  rst mid-operation: every channel returns to reset state at the next edge, and no timeout is emitted.
// TESTING
//  - Reset: after rst, every output is 0 for any inputs, until start. Also assert rst during a
//    channel-1 run at count 4 -> running = 0, count = 0, pending = 0 at the next edge.
//  - One-shot: ch0 reload = 5, presc_div = 0, start at edge 0 -> count 5..0 over cycles 1..6,
//    timeout = 1 only in cycle 7, running = 0 from cycle 7, pending = 1, irq = 1 if irq_en[0].
//  - Periodic + prescaler: ch1 reload = 1, periodic, presc_div = 2 -> timeout pulses exactly
//    6 cycles apart; a mid-run cfg write of reload = 3 changes spacing to 12 only after the next expiry.
//  - Stop/restart: ch2 reload = 10, stop at count 4 -> count holds 4, no timeout.
//    Start during a run at count 7 -> count = 10 next cycle.
//  - Flag race: irq_clr[0] in the same cycle as ch0 expiry -> pending stays 1.
//    irq_clr alone later -> pending = 0, irq = 0.
//  - Concurrency: ch0 and ch3 with reload = 2, started together, presc_div = 0 -> both timeouts
//    in the same cycle; an invalid cfg_ch write changes nothing.

Source files
------------

// File: rtl/multi_timer.sv
// Multi-channel programmable down-counting timer with a shared clock prescaler.
// Each channel has its own reload, one-shot/periodic mode, timeout pulse and sticky pending flag.
module multi_timer #(
    parameter int NUM_CH  = 4,
    parameter int WIDTH   = 16,
    parameter int PRESC_W = 8,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PRESC_W-1:0]      presc_div,
    input  logic                    cfg_we,
    input  logic [CH_W-1:0]         cfg_ch,
    input  logic [WIDTH-1:0]        cfg_reload,
    input  logic                    cfg_periodic,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       stop,
    input  logic [NUM_CH-1:0]       irq_en,
    input  logic [NUM_CH-1:0]       irq_clr,
    output logic [NUM_CH-1:0]       running,
    output logic [NUM_CH-1:0]       timeout,
    output logic [NUM_CH-1:0]       pending,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic                    irq
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    logic [PRESC_W-1:0] presc_cnt;
    logic               tick;

    logic [WIDTH-1:0]   reload_q   [NUM_CH];
    logic               periodic_q [NUM_CH];
    logic [WIDTH-1:0]   count_q    [NUM_CH];
    logic [WIDTH-1:0]   count_d    [NUM_CH];
    state_t             state_q    [NUM_CH];
    state_t             state_d    [NUM_CH];
    logic [NUM_CH-1:0]  expire;
    logic [NUM_CH-1:0]  timeout_q;
    logic [NUM_CH-1:0]  pending_q;

    // Equality (not >=) keeps a lowered presc_div from cutting the current period short:
    // the counter simply runs on to all-ones and wraps.
    assign tick = (presc_cnt == presc_div);

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + PRESC_W'(1);
        end
    end

    // NOTE: the reload/mode registers are architecturally visible after reset, so they are reset too.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                reload_q[i]   <= '0;
                periodic_q[i] <= 1'b0;
            end
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_ch == CH_W'(i)) begin
                    reload_q[i]   <= cfg_reload;
                    periodic_q[i] <= cfg_periodic;
                end
            end
        end
    end

    // NOTE: every next-state signal gets its default first, so no latches are inferred.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            count_d[i] = count_q[i];
            expire[i]  = 1'b0;
            if (start[i]) begin
                count_d[i] = reload_q[i];
                state_d[i] = RUN;
            end else if (stop[i]) begin
                state_d[i] = IDLE;
            end else if (state_q[i] == RUN && tick) begin
                if (count_q[i] == '0) begin
                    expire[i] = 1'b1;
                    if (periodic_q[i]) begin
                        count_d[i] = reload_q[i];
                    end else begin
                        state_d[i] = IDLE;
                    end
                end else begin
                    count_d[i] = count_q[i] - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                count_q[i] <= '0;
            end
            timeout_q <= '0;
            pending_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                count_q[i] <= count_d[i];
            end
            timeout_q <= expire;
            pending_q <= expire | (pending_q & ~irq_clr);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign running[g]                = (state_q[g] == RUN);
        assign count[g*WIDTH +: WIDTH]   = count_q[g];
    end

    assign timeout = timeout_q;
    assign pending = pending_q;
    assign irq     = |(pending_q & irq_en);

endmodule
